// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR definitions for the trap/interrupt path.
//   - CSR addresses of the machine-mode trap registers
//   - mstatus / mip / mie bit positions
//   - interrupt cause codes
//   - trap sequencer state encoding
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAP_SAVE = 2'd1,
        ST_TRAP_JUMP = 2'd2,
        ST_MRET_JUMP = 2'd3
    } trap_state_t;

endpackage

// File: rtl/irq_sync.sv
// irq_sync: SYNC_STAGES-deep flop chain that brings an asynchronous level
// into the clk domain.
//   clk     : destination clock
//   reset   : async active-low reset, clears the chain
//   i_async : asynchronous level input
//   o_sync  : synchronised level, SYNC_STAGES cycles of latency
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_chain <= '0;
        else        r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: interrupt/mret sequencer in front of the CSR file.
//   Inputs : irq_ext_i / irq_timer_i (async levels), MW-stage instr_valid_i,
//            mret_i, pc_mw_i, and the live mstatus/mie/mtvec/mepc.
//   Outputs: mip_o (synced pending bits), kill_o (drop MW writeback),
//            csr_trap_we_o / csr_mstatus_we_o strobes with *_wdata_o,
//            redirect_o / redirect_pc_o / flush_o to fetch, busy_o (stall).
// A trap takes acceptance + TRAP_SAVE + TRAP_JUMP; mret takes acceptance +
// MRET_JUMP. All strobed outputs are decoded from the state register.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            instr_valid_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pc_mw_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] mip_o,
    output logic            kill_o,
    output logic            csr_trap_we_o,
    output logic            csr_mstatus_we_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic [XLEN-1:0] mcause_wdata_o,
    output logic [XLEN-1:0] mstatus_wdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            busy_o
);

    trap_state_t     r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;

    logic            w_meip, w_mtip;
    logic            w_idle, w_ext_take, w_tmr_take;
    logic            w_acc_mret, w_acc_trap;
    logic [XLEN-1:0] w_tvec_base, w_vec_off;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk), .reset(reset), .i_async(irq_ext_i), .o_sync(w_meip)
    );
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr (
        .clk(clk), .reset(reset), .i_async(irq_timer_i), .o_sync(w_mtip)
    );

    always_comb begin
        mip_o           = '0;
        mip_o[MIP_MEIP] = w_meip;
        mip_o[MIP_MTIP] = w_mtip;
    end

    assign w_ext_take = w_meip & mie_i[MIP_MEIP] & mstatus_i[MSTATUS_MIE];
    assign w_tmr_take = w_mtip & mie_i[MIP_MTIP] & mstatus_i[MSTATUS_MIE];
    assign w_idle     = (r_state == ST_IDLE);

    // mret wins over a same-cycle interrupt; the interrupt is simply
    // re-evaluated on the next valid IDLE cycle.
    assign w_acc_mret = w_idle & instr_valid_i & mret_i;
    assign w_acc_trap = w_idle & instr_valid_i & ~mret_i & (w_ext_take | w_tmr_take);

    assign kill_o = w_acc_trap;
    assign busy_o = ~w_idle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_mret) begin
                        r_state <= ST_MRET_JUMP;
                    end else if (w_acc_trap) begin
                        r_state <= ST_TRAP_SAVE;
                        r_pc    <= pc_mw_i;
                        r_cause <= w_ext_take ? XLEN'(CAUSE_MEI) : XLEN'(CAUSE_MTI);
                    end
                end
                ST_TRAP_SAVE: r_state <= ST_TRAP_JUMP;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
    // Vectored mode: base + 4*cause[4:0], wrapping at XLEN bits.
    assign w_vec_off   = {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};

    always_comb begin
        csr_trap_we_o    = 1'b0;
        csr_mstatus_we_o = 1'b0;
        mepc_wdata_o     = '0;
        mcause_wdata_o   = '0;
        mstatus_wdata_o  = '0;
        redirect_o       = 1'b0;
        redirect_pc_o    = '0;
        flush_o          = 1'b0;
        case (r_state)
            ST_TRAP_SAVE: begin
                csr_trap_we_o   = 1'b1;
                mepc_wdata_o    = r_pc;
                mcause_wdata_o  = r_cause;
                mstatus_wdata_o = mstatus_i;
                mstatus_wdata_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
                mstatus_wdata_o[MSTATUS_MIE]  = 1'b0;
                mstatus_wdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            ST_TRAP_JUMP: begin
                redirect_o    = 1'b1;
                flush_o       = 1'b1;
                redirect_pc_o = (mtvec_i[1:0] == 2'b01) ? w_tvec_base + w_vec_off
                                                        : w_tvec_base;
            end
            ST_MRET_JUMP: begin
                csr_mstatus_we_o = 1'b1;
                redirect_o       = 1'b1;
                flush_o          = 1'b1;
                redirect_pc_o    = {mepc_i[XLEN-1:2], 2'b00};
                mstatus_wdata_o  = mstatus_i;
                mstatus_wdata_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
                mstatus_wdata_o[MSTATUS_MPIE] = 1'b1;
                mstatus_wdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            default: ;
        endcase
    end

    // Only a few bits of mie and none of mepc[1:0] matter here.
    logic w_unused;
    assign w_unused = ^{mie_i, mepc_i[1:0]};

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_ext_i, irq_timer_i, instr_valid_i, mret_i;
    logic [31:0] pc_mw_i, mstatus_i, mie_i, mtvec_i, mepc_i;
    logic [31:0] mip_o, mepc_wdata_o, mcause_wdata_o, mstatus_wdata_o, redirect_pc_o;
    logic        kill_o, csr_trap_we_o, csr_mstatus_we_o, redirect_o, flush_o, busy_o;

    csr_trap_ctrl #(.XLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .instr_valid_i(instr_valid_i), .mret_i(mret_i), .pc_mw_i(pc_mw_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .mip_o(mip_o), .kill_o(kill_o),
        .csr_trap_we_o(csr_trap_we_o), .csr_mstatus_we_o(csr_mstatus_we_o),
        .mepc_wdata_o(mepc_wdata_o), .mcause_wdata_o(mcause_wdata_o),
        .mstatus_wdata_o(mstatus_wdata_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mstatus;
    } save_t;

    save_t       q_save[$];
    logic [31:0] q_mret[$];
    logic [31:0] q_redir[$];
    save_t       mon_e;

    function automatic logic [31:0] ms_trap(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (m[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] ms_mret(input logic [31:0] m);
        return (m & ~32'h0000_1808) | (m[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
    endfunction

    // Scoreboard monitor: every strobe pops the oldest expectation.
    always @(negedge clk) begin
        if (csr_trap_we_o) begin
            if (q_save.size() == 0) chk("unexp_trap_we", 1, 0);
            else begin
                mon_e = q_save.pop_front();
                chk("mepc_wdata", mepc_wdata_o, mon_e.mepc);
                chk("mcause_wdata", mcause_wdata_o, mon_e.mcause);
                chk("trap_mstatus_wdata", mstatus_wdata_o, mon_e.mstatus);
            end
        end
        if (csr_mstatus_we_o) begin
            if (q_mret.size() == 0) chk("unexp_mstatus_we", 1, 0);
            else chk("mret_mstatus_wdata", mstatus_wdata_o, q_mret.pop_front());
        end
        if (redirect_o) begin
            if (q_redir.size() == 0) chk("unexp_redirect", 1, 0);
            else chk("redirect_pc", redirect_pc_o, q_redir.pop_front());
            chk("flush_with_redir", flush_o, 1);
        end else begin
            chk("redir_pc_idle0", redirect_pc_o, 0);
        end
        if (!csr_trap_we_o && !csr_mstatus_we_o)
            chk("wdata_idle0", mepc_wdata_o | mcause_wdata_o | mstatus_wdata_o, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take_trap(input logic [31:0] pc, input logic [31:0] ms,
                             input logic [31:0] tvec, input logic [31:0] cause,
                             input logic [31:0] rpc);
        save_t e;
        step();
        pc_mw_i = pc; mstatus_i = ms; mtvec_i = tvec;
        instr_valid_i = 1'b1; mret_i = 1'b0;
        e.mepc = pc; e.mcause = cause; e.mstatus = ms_trap(ms);
        q_save.push_back(e);
        q_redir.push_back(rpc);
        @(negedge clk);
        chk("acc_kill", kill_o, 1);
        chk("acc_busy", busy_o, 0);
        step();
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("save_we", csr_trap_we_o, 1);
        chk("save_no_redir", redirect_o, 0);
        chk("save_busy", busy_o, 1);
        step();
        @(negedge clk);
        chk("jump_redir", redirect_o, 1);
        chk("jump_kill0", kill_o, 0);
        step();
        @(negedge clk);
        chk("post_trap_busy", busy_o, 0);
    endtask

    task automatic do_mret(input logic [31:0] ms, input logic [31:0] epc,
                           input logic [31:0] exp_ms, input logic [31:0] exp_pc);
        step();
        mstatus_i = ms; mepc_i = epc; instr_valid_i = 1'b1; mret_i = 1'b1;
        q_mret.push_back(exp_ms);
        q_redir.push_back(exp_pc);
        @(negedge clk);
        chk("mret_no_kill", kill_o, 0);
        chk("mret_acc_busy", busy_o, 0);
        step();
        mret_i = 1'b0; instr_valid_i = 1'b0;
        @(negedge clk);
        chk("mret_we", csr_mstatus_we_o, 1);
        chk("mret_redir", redirect_o, 1);
        chk("mret_no_trap_we", csr_trap_we_o, 0);
        step();
        @(negedge clk);
        chk("post_mret_busy", busy_o, 0);
    endtask

    task automatic no_take(input string tag, input logic [31:0] ms,
                           input logic [31:0] ie, input logic v);
        step();
        mstatus_i = ms; mie_i = ie; instr_valid_i = v; mret_i = 1'b0;
        @(negedge clk);
        chk(tag, kill_o, 0);
        step();
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        logic [31:0] tv, ms, rpc;
        reset = 1'b0;
        irq_ext_i = 1'b1; irq_timer_i = 1'b0;
        instr_valid_i = 1'b0; mret_i = 1'b0;
        pc_mw_i = '0; mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;

        // Reset held with ext irq high: everything quiet.
        repeat (3) @(negedge clk);
        chk("rst_mip", mip_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_strobes", {27'd0, kill_o, csr_trap_we_o, csr_mstatus_we_o, redirect_o, flush_o}, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("sync_lat1", mip_o, 0);
        @(negedge clk);
        chk("sync_lat2", mip_o, 32'h800);

        // Basic external trap, direct mode.
        step(); mie_i = 32'h800;
        take_trap(32'h40, 32'h8, 32'h100, CAUSE_MEI, 32'h100);

        // Both pending, vectored: external wins.
        step(); irq_timer_i = 1'b1; mie_i = 32'h880;
        repeat (3) step();
        chk("mip_both", mip_o, 32'h880);
        take_trap(32'h80, 32'h8, 32'h101, CAUSE_MEI, 32'h12C);

        // Masking: MIE off, mie off, bubble.
        no_take("mask_mie_bit", 32'h0, 32'h880, 1'b1);
        no_take("mask_mie_reg", 32'h8, 32'h0,   1'b1);
        no_take("mask_bubble",  32'h8, 32'h880, 1'b0);
        take_trap(32'h90, 32'h8, 32'h100, CAUSE_MEI, 32'h100);

        // Timer only, vectored.
        step(); irq_ext_i = 1'b0;
        repeat (3) step();
        take_trap(32'hA0, 32'h8, 32'h101, CAUSE_MTI, 32'h11C);

        // mret with timer pending; second one has MIE=1 so mret must win.
        step(); mtvec_i = 32'h200;
        do_mret(32'h1880, 32'h44, 32'h1888, 32'h44);
        take_trap(32'h48, 32'h1888, 32'h200, CAUSE_MTI, 32'h200);
        do_mret(32'h0008, 32'h4B, ms_mret(32'h0008), 32'h48);
        take_trap(32'h4C, 32'h0008, 32'h200, CAUSE_MTI, 32'h200);

        // Random mstatus/mtvec, including a vector address that wraps.
        step(); irq_timer_i = 1'b0; irq_ext_i = 1'b1; mie_i = 32'h800;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            tv = (i == 4) ? 32'hFFFF_FFF1 : $urandom;
            if (i % 2 == 0) tv[1:0] = 2'b01;
            ms = $urandom | 32'h8;
            rpc = {tv[31:2], 2'b00};
            if (tv[1:0] == 2'b01) rpc = rpc + 32'd44;
            take_trap($urandom, ms, tv, CAUSE_MEI, rpc);
        end

        // Reset during TRAP_SAVE aborts the sequence.
        step(); mstatus_i = 32'h8; mtvec_i = 32'h100; instr_valid_i = 1'b1;
        @(negedge clk);
        chk("mid_acc_kill", kill_o, 1);
        step(); instr_valid_i = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", csr_trap_we_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_mip", mip_o, 0);
        step(); reset = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("mid_post_busy", busy_o, 0);

        chk("q_save_left", q_save.size(), 0);
        chk("q_mret_left", q_mret.size(), 0);
        chk("q_redir_left", q_redir.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
